sis_sched: RTL and testbench

SIS_SCHED -- requirements
Module: sis_sched

---
 rtl/sis_sched.sv | 142 ++++++++++++++
 tb/tb_sis_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sis_sched.sv
// rtl/sis_sched.sv - row scheduler feeding the transform input-selection datapath
module sis_sched #(
   parameter int WIDTH = 16,
   parameter int MAX_N = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           cfg_valid,
   output logic                           cfg_ready,
   input  logic [1:0]                     cfg_type,
   input  logic [2:0]                     cfg_log2n,
   input  logic [5:0]                     cfg_rows,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [MAX_N*WIDTH-1:0]  in_row,
   output logic [1:0]                     sis_type,
   output logic signed [MAX_N*WIDTH-1:0]  sis_row,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [4:0]                     out_row_idx,
   output logic                           busy,
   output logic                           err_cfg
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t                  state_q, state_d;
   logic [1:0]              type_q, type_d;
   logic [31:0]             n_q, n_d;
   logic [5:0]              rows_q, rows_d;
   logic                    first_q, first_d;
   logic [4:0]              idx_q, idx_d;
   logic                    last_q, last_d;
   logic                    valid_q, valid_d;
   logic [MAX_N*WIDTH-1:0]  row_q, row_d;
   logic                    err_q, err_d;

   logic                    cfg_legal;
   logic                    accept;
   logic [4:0]              next_idx;
   logic                    next_is_last;

   assign cfg_ready   = (state_q == S_IDLE);
   assign in_ready    = (state_q == S_RUN) && (!valid_q || out_ready);
   assign busy        = (state_q != S_IDLE);
   assign sis_type    = type_q;
   assign sis_row     = row_q;
   assign out_valid   = valid_q;
   assign out_last    = last_q;
   assign out_row_idx = idx_q;
   assign err_cfg     = err_q;

   assign cfg_legal    = (cfg_type != 2'b11) && (cfg_log2n >= 3'd2) && (cfg_log2n <= 3'd5)
                         && (cfg_rows != 6'd0) && (cfg_rows <= 6'd32);
   assign accept       = in_valid && in_ready;
   // The first accepted row of a block gets index 0; later rows count up from there.
   assign next_idx     = first_q ? 5'd0 : idx_q + 5'd1;
   assign next_is_last = ({1'b0, next_idx} == rows_q - 6'd1);

   // Next-state and datapath update: config latch, row capture with lane masking, handshake.
   always_comb begin
      state_d = state_q;
      type_d  = type_q;
      n_d     = n_q;
      rows_d  = rows_q;
      first_d = first_q;
      idx_d   = idx_q;
      last_d  = last_q;
      valid_d = valid_q;
      row_d   = row_q;
      err_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cfg_valid) begin
               if (cfg_legal) begin
                  type_d  = cfg_type;
                  n_d     = 32'd1 << cfg_log2n;
                  rows_d  = cfg_rows;
                  first_d = 1'b1;
                  idx_d   = 5'd0;
                  last_d  = 1'b0;
                  state_d = S_RUN;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (accept && next_is_last) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (valid_q && out_ready && last_q) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (accept) begin
         valid_d = 1'b1;
         idx_d   = next_idx;
         last_d  = next_is_last;
         first_d = 1'b0;
         for (int i = 0; i < MAX_N; i++) begin
            row_d[i*WIDTH +: WIDTH] = ($unsigned(i) < n_q) ? in_row[i*WIDTH +: WIDTH] : '0;
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
         last_d  = 1'b0;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Block configuration, output row and handshake registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         type_q  <= 2'b00;
         n_q     <= 32'd0;
         rows_q  <= 6'd0;
         first_q <= 1'b0;
         idx_q   <= 5'd0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         row_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         type_q  <= type_d;
         n_q     <= n_d;
         rows_q  <= rows_d;
         first_q <= first_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         valid_q <= valid_d;
         row_q   <= row_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_sis_sched.sv
// tb/tb_sis_sched.sv - self-checking bench for sis_sched with a row scoreboard
module tb_sis_sched;

   localparam int WIDTH = 16;
   localparam int MAX_N = 32;
   localparam int W     = WIDTH * MAX_N;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_type;
   logic [2:0]    cfg_log2n;
   logic [5:0]    cfg_rows;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_row;
   logic [1:0]    sis_type;
   logic [W-1:0]  sis_row;
   logic          out_valid;
   logic          out_ready;
   logic          out_last;
   logic [4:0]    out_row_idx;
   logic          busy;
   logic          err_cfg;

   sis_sched #(.WIDTH(WIDTH), .MAX_N(MAX_N)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_type(cfg_type),
      .cfg_log2n(cfg_log2n), .cfg_rows(cfg_rows),
      .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
      .sis_type(sis_type), .sis_row(sis_row), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .out_row_idx(out_row_idx),
      .busy(busy), .err_cfg(err_cfg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] row;
      logic [4:0]   idx;
      logic         last;
      logic [1:0]   typ;
   } exp_t;

   exp_t sbq[$];

   int errors = 0;
   int checks = 0;
   int pops = 0;
   int err_pulses = 0;
   int m_n = 0;
   int m_rows = 0;
   int m_cnt = 0;
   logic [1:0] m_typ = 2'b00;

   logic          s_ov, s_ir, s_busy, s_cr, s_err, s_last;
   logic [W-1:0]  s_row;
   logic [4:0]    s_idx;
   logic [1:0]    s_typ;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_row();
      logic [W-1:0] r;
      for (int i = 0; i < MAX_N; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      return r;
   endfunction

   // One clock: sample at the falling edge, run the scoreboard, then advance past the rising edge.
   task automatic step();
      exp_t e;
      logic acc;
      @(negedge clk);
      s_ov = out_valid; s_ir = in_ready; s_busy = busy; s_cr = cfg_ready; s_err = err_cfg;
      s_row = sis_row; s_idx = out_row_idx; s_last = out_last; s_typ = sis_type;
      acc = in_valid && in_ready;
      if (cfg_valid && cfg_ready && cfg_type != 2'd3 && cfg_log2n inside {[2:5]}
          && cfg_rows inside {[1:32]}) begin
         m_typ  = cfg_type;
         m_n    = 1 << cfg_log2n;
         m_rows = int'(cfg_rows);
         m_cnt  = 0;
      end
      if (err_cfg) err_pulses++;
      if (out_valid && out_ready) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected_row", W'(out_valid), W'(0));
         end else begin
            e = sbq.pop_front();
            pops++;
            chk("sb_row", sis_row, e.row);
            chk("sb_idx", W'(out_row_idx), W'(e.idx));
            chk("sb_last", W'(out_last), W'(e.last));
            chk("sb_type", W'(sis_type), W'(e.typ));
         end
      end
      if (acc) begin
         chk("accept_within_block", W'(m_cnt < m_rows), W'(1));
         for (int i = 0; i < MAX_N; i++)
            e.row[i*WIDTH +: WIDTH] = (i < m_n) ? in_row[i*WIDTH +: WIDTH] : '0;
         e.idx  = 5'(m_cnt);
         e.last = (m_cnt == m_rows - 1);
         e.typ  = m_typ;
         sbq.push_back(e);
         m_cnt++;
      end
      @(posedge clk);
      #1;
      if (acc) in_row = rand_row();
   endtask

   task automatic do_cfg(input logic [1:0] t, input logic [2:0] l, input logic [5:0] r);
      cfg_valid = 1'b1; cfg_type = t; cfg_log2n = l; cfg_rows = r;
      step();
      cfg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [5:0]   ov_pat;
      logic [W-1:0] exp38;
      logic [W-1:0] snap_row;
      logic [4:0]   snap_idx;
      int           p0;
      int           e0;

      rst_n = 1'b0; cfg_valid = 1'b0; cfg_type = 2'b00; cfg_log2n = 3'd0; cfg_rows = 6'd0;
      in_valid = 1'b0; in_row = '0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", W'(out_valid), W'(0));
      chk("rst_busy", W'(busy), W'(0));
      chk("rst_cfg_ready", W'(cfg_ready), W'(1));
      chk("rst_in_ready", W'(in_ready), W'(0));
      chk("rst_sis_row", sis_row, W'(0));
      chk("rst_idx_last_type_err", W'({out_row_idx, out_last, sis_type, err_cfg}), W'(0));
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Full-rate DCT2 block, 4 rows of 32 lanes.
      out_ready = 1'b1;
      do_cfg(2'b00, 3'd5, 6'd4);
      in_valid = 1'b1; in_row = rand_row();
      ov_pat = '0;
      for (int c = 0; c < 6; c++) begin
         step();
         ov_pat = {ov_pat[4:0], s_ov};
      end
      chk("fullrate_valid_pattern", W'(ov_pat), W'(6'b011110));
      chk("fullrate_idle_after", W'(s_busy), W'(0));
      chk("fullrate_rows_out", W'(pops), W'(4));
      in_valid = 1'b0;

      // Single-row DST7 block with N=4: upper lanes must be zeroed.
      do_cfg(2'b01, 3'd2, 6'd1);
      for (int i = 0; i < MAX_N; i++) in_row[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      exp38 = '0;
      for (int i = 0; i < 4; i++) exp38[i*WIDTH +: WIDTH] = WIDTH'(i + 1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("n4_row", s_row, exp38);
      chk("n4_type", W'(s_typ), W'(2'b01));
      chk("n4_last", W'(s_last), W'(1));
      step();
      chk("n4_idle", W'(s_busy), W'(0));

      // DCT8 block of 3 rows with a 3-cycle downstream stall after the first row.
      p0 = pops;
      do_cfg(2'b10, 3'd3, 6'd3);
      in_valid = 1'b1; in_row = rand_row();
      step();
      out_ready = 1'b0;
      step();
      snap_row = s_row; snap_idx = s_idx;
      chk("stall_in_ready0", W'(s_ir), W'(0));
      chk("stall_valid", W'(s_ov), W'(1));
      for (int k = 0; k < 2; k++) begin
         step();
         chk("stall_in_ready", W'(s_ir), W'(0));
         chk("stall_row_stable", s_row, snap_row);
         chk("stall_idx_stable", W'(s_idx), W'(snap_idx));
      end
      out_ready = 1'b1;
      for (int k = 0; k < 12 && busy; k++) step();
      in_valid = 1'b0;
      chk("stall_done", W'(busy), W'(0));
      chk("stall_rows_out", W'(pops - p0), W'(3));
      chk("stall_sb_empty", W'(sbq.size()), W'(0));

      // Three illegal configurations, each rejected with a single err_cfg pulse.
      e0 = err_pulses;
      do_cfg(2'b11, 3'd3, 6'd4);
      chk("ill_type_cfg_ready", W'(s_cr), W'(1));
      step();
      chk("ill_type_err", W'(s_err), W'(1));
      chk("ill_type_busy", W'(s_busy), W'(0));
      do_cfg(2'b00, 3'd1, 6'd4);
      chk("ill_log2n_cfg_ready", W'(s_cr), W'(1));
      step();
      chk("ill_log2n_err", W'(s_err), W'(1));
      do_cfg(2'b01, 3'd4, 6'd0);
      chk("ill_rows_cfg_ready", W'(s_cr), W'(1));
      step();
      chk("ill_rows_err", W'(s_err), W'(1));
      step();
      chk("ill_err_cleared", W'(s_err), W'(0));
      chk("ill_busy", W'(s_busy), W'(0));
      chk("ill_pulse_count", W'(err_pulses - e0), W'(3));
      chk("ill_type_kept", W'(s_typ), W'(2'b10));

      // Reset in the middle of an 8-row block, then a fresh 2-row block.
      do_cfg(2'b00, 3'd4, 6'd8);
      in_valid = 1'b1; in_row = rand_row();
      for (int k = 0; k < 8 && m_cnt < 3; k++) step();
      chk("midrst_rows_taken", W'(m_cnt), W'(3));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", W'(out_valid), W'(0));
      chk("midrst_busy", W'(busy), W'(0));
      chk("midrst_cfg_ready", W'(cfg_ready), W'(1));
      chk("midrst_sis_row", sis_row, W'(0));
      chk("midrst_idx_last_type_err", W'({out_row_idx, out_last, sis_type, err_cfg}), W'(0));
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("postrst_no_valid", W'(s_ov), W'(0));
      end
      p0 = pops;
      do_cfg(2'b00, 3'd4, 6'd2);
      for (int k = 0; k < 10 && busy; k++) step();
      in_valid = 1'b0;
      chk("postrst_done", W'(busy), W'(0));
      chk("postrst_rows_out", W'(pops - p0), W'(2));
      chk("postrst_sb_empty", W'(sbq.size()), W'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
